// File: rtl/touch_uart_rx.sv
// touch_uart_rx: oversampling 8N1 receiver that parses 5-byte touch packets into
// {pen, x, y} events and hands them out through a show-ahead FIFO (valid/ready).
module touch_uart_rx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int COORD_W    = 12
) (
  input  logic                            clk_clk,
  input  logic                            reset_reset_n,
  input  logic                            touch_uart_RXD,
  output logic                            touch_uart_TXD,
  output logic                            evt_valid,
  input  logic                            evt_ready,
  output logic                            evt_pen,
  output logic [COORD_W-1:0]              evt_x,
  output logic [COORD_W-1:0]              evt_y,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            frame_err,
  output logic                            overflow,
  input  logic                            clr_overflow
);

  localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TICK_W  = $clog2(OVERSAMPLE);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int EVT_W   = 1 + 2 * COORD_W;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_SYNC, P_XL, P_XH, P_YL, P_YH} prs_state_t;

  logic              r_rst_meta;
  logic              r_rst_n;
  logic              r_rxd_s1;
  logic              r_rxd_s2;
  logic              r_rxd_d;
  logic              w_fall;
  logic [DIV_W-1:0]  r_div_cnt;
  logic              w_tick;
  logic [TICK_W-1:0] r_tick_cnt;
  logic              w_sample_pt;
  logic              w_start_edge;
  rx_state_t         r_rx_state;
  rx_state_t         w_rx_next;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic              w_byte_stb;
  logic              w_frame_bad;
  logic              r_frame_err;

  prs_state_t        r_prs_state;
  prs_state_t        w_prs_next;
  logic              w_is_hdr;
  logic              w_pkt_done;
  logic              r_pen;
  logic [6:0]        r_xl;
  logic [4:0]        r_xh;
  logic [6:0]        r_yl;
  logic [11:0]       w_raw_x;
  logic [11:0]       w_raw_y;
  logic              r_push;
  logic [EVT_W-1:0]  r_push_evt;

  logic [EVT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_do_push;
  logic              w_ovf_set;
  logic              r_overflow;
  logic [EVT_W-1:0]  w_head;

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_rst_meta <= 1'b0;
      r_rst_n    <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_n    <= r_rst_meta;
    end
  end

  always_ff @(posedge clk_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_rxd_s1 <= 1'b1;
      r_rxd_s2 <= 1'b1;
      r_rxd_d  <= 1'b1;
    end else begin
      r_rxd_s1 <= touch_uart_RXD;
      r_rxd_s2 <= r_rxd_s1;
      r_rxd_d  <= r_rxd_s2;
    end
  end

  assign w_fall       = r_rxd_d & ~r_rxd_s2;
  assign w_start_edge = (r_rx_state == RX_IDLE) & w_fall;
  assign w_tick       = (r_div_cnt == DIV_W'(DIV - 1));

  always_comb begin
    w_sample_pt = 1'b0;
    if (w_tick) begin
      if (r_rx_state == RX_START)
        w_sample_pt = (r_tick_cnt == TICK_W'(OVERSAMPLE / 2 - 1));
      else if (r_rx_state == RX_DATA || r_rx_state == RX_STOP)
        w_sample_pt = (r_tick_cnt == TICK_W'(OVERSAMPLE - 1));
    end
  end

  // Both counters restart on the start edge so the first sample lands mid start bit.
  always_ff @(posedge clk_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_div_cnt  <= '0;
      r_tick_cnt <= '0;
    end else begin
      if (w_start_edge || w_tick)
        r_div_cnt <= '0;
      else
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      if (w_start_edge || w_sample_pt)
        r_tick_cnt <= '0;
      else if (w_tick)
        r_tick_cnt <= r_tick_cnt + TICK_W'(1);
    end
  end

  always_ff @(posedge clk_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_rx_state  <= RX_IDLE;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'd0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_state  <= w_rx_next;
      r_frame_err <= w_frame_bad;
      if (w_sample_pt && r_rx_state == RX_START)
        r_bit_idx <= 3'd0;
      else if (w_sample_pt && r_rx_state == RX_DATA) begin
        r_bit_idx <= r_bit_idx + 3'd1;
        r_shift   <= {r_rxd_s2, r_shift[7:1]};
      end
    end
  end

  always_comb begin
    w_rx_next   = r_rx_state;
    w_byte_stb  = 1'b0;
    w_frame_bad = 1'b0;
    case (r_rx_state)
      RX_IDLE:  if (w_fall) w_rx_next = RX_START;
      RX_START: if (w_sample_pt) w_rx_next = r_rxd_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_sample_pt && r_bit_idx == 3'd7) w_rx_next = RX_STOP;
      RX_STOP: begin
        if (w_sample_pt) begin
          w_rx_next = RX_IDLE;
          if (r_rxd_s2)
            w_byte_stb = 1'b1;
          else
            w_frame_bad = 1'b1;
        end
      end
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  assign w_is_hdr = (r_shift[7:1] == 7'b1000000);
  assign w_raw_x  = {r_xh, r_xl};
  assign w_raw_y  = {r_shift[4:0], r_yl};

  // Any header restarts a packet; any other byte with bit7 set abandons it.
  always_comb begin
    w_prs_next = r_prs_state;
    w_pkt_done = 1'b0;
    if (w_frame_bad)
      w_prs_next = P_SYNC;
    else if (w_byte_stb) begin
      if (w_is_hdr)
        w_prs_next = P_XL;
      else if (r_shift[7])
        w_prs_next = P_SYNC;
      else begin
        case (r_prs_state)
          P_SYNC:  w_prs_next = P_SYNC;
          P_XL:    w_prs_next = P_XH;
          P_XH:    w_prs_next = P_YL;
          P_YL:    w_prs_next = P_YH;
          P_YH: begin
            w_prs_next = P_SYNC;
            w_pkt_done = 1'b1;
          end
          default: w_prs_next = P_SYNC;
        endcase
      end
    end
  end

  always_ff @(posedge clk_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_prs_state <= P_SYNC;
      r_pen       <= 1'b0;
      r_xl        <= 7'd0;
      r_xh        <= 5'd0;
      r_yl        <= 7'd0;
      r_push      <= 1'b0;
      r_push_evt  <= '0;
    end else begin
      r_prs_state <= w_prs_next;
      r_push      <= w_pkt_done;
      if (w_byte_stb && w_is_hdr)
        r_pen <= r_shift[0];
      if (w_byte_stb && !r_shift[7]) begin
        case (r_prs_state)
          P_XL:    r_xl <= r_shift[6:0];
          P_XH:    r_xh <= r_shift[4:0];
          P_YL:    r_yl <= r_shift[6:0];
          default: ;
        endcase
      end
      if (w_pkt_done)
        r_push_evt <= {r_pen, w_raw_x[11 -: COORD_W], w_raw_y[11 -: COORD_W]};
    end
  end

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop     = ~w_empty & evt_ready;
  assign w_do_push = r_push & (~w_full | w_pop);
  assign w_ovf_set = r_push & w_full & ~w_pop;

  always_ff @(posedge clk_clk) begin
    if (w_do_push)
      r_mem[r_wptr] <= r_push_evt;
  end

  // A simultaneous pop frees the slot a full FIFO is about to write into.
  always_ff @(posedge clk_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push)
        r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)
        r_rptr <= r_rptr + PTR_W'(1);
      if (w_do_push && !w_pop)
        r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_do_push)
        r_count <= r_count - CNT_W'(1);
      if (w_ovf_set)
        r_overflow <= 1'b1;
      else if (clr_overflow)
        r_overflow <= 1'b0;
    end
  end

  assign w_head         = r_mem[r_rptr];
  assign touch_uart_TXD = 1'b1;
  assign evt_valid      = ~w_empty;
  assign evt_pen        = evt_valid ? w_head[EVT_W-1] : 1'b0;
  assign evt_x          = evt_valid ? w_head[2*COORD_W-1:COORD_W] : '0;
  assign evt_y          = evt_valid ? w_head[COORD_W-1:0] : '0;
  assign fifo_count     = r_count;
  assign frame_err      = r_frame_err;
  assign overflow       = r_overflow;

endmodule

// File: tb/tb_touch_uart_rx.sv
`timescale 1ns/1ps
// tb_touch_uart_rx: randomized bench for touch_uart_rx; events are predicted by a
// byte-level packet model (queues) and compared at the FIFO head.
module tb_touch_uart_rx;

  localparam int BIT_M = 40;
  localparam int BIT_8 = 160;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic        pen;
    logic [11:0] x;
    logic [11:0] y;
  } evt_t;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b1;
  logic        rxd    = 1'b1;
  logic        rxd8   = 1'b1;
  logic        ready  = 1'b0;
  logic        ready8 = 1'b0;
  logic        clr    = 1'b0;
  logic        clr8   = 1'b0;
  logic        txd, valid, pen, ferr, ovf;
  logic [11:0] x, y;
  logic [2:0]  cnt;
  logic        txd8, valid8, pen8, ferr8, ovf8;
  logic [7:0]  x8, y8;
  logic [4:0]  cnt8;

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   fe_hi        = 0;
  int   fe8_hi       = 0;
  evt_t exp_q[$];
  logic [7:0] part_q[$];
  bit   exp_ovf;

  touch_uart_rx #(.CLK_HZ(1600000), .BAUD(40000), .OVERSAMPLE(8),
                  .FIFO_DEPTH(DEPTH), .COORD_W(12)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .touch_uart_RXD(rxd),
    .touch_uart_TXD(txd), .evt_valid(valid), .evt_ready(ready),
    .evt_pen(pen), .evt_x(x), .evt_y(y), .fifo_count(cnt),
    .frame_err(ferr), .overflow(ovf), .clr_overflow(clr));

  touch_uart_rx #(.CLK_HZ(1600000), .BAUD(10000), .OVERSAMPLE(16),
                  .FIFO_DEPTH(16), .COORD_W(8)) dut8 (
    .clk_clk(clk), .reset_reset_n(rst_n), .touch_uart_RXD(rxd8),
    .touch_uart_TXD(txd8), .evt_valid(valid8), .evt_ready(ready8),
    .evt_pen(pen8), .evt_x(x8), .evt_y(y8), .fifo_count(cnt8),
    .frame_err(ferr8), .overflow(ovf8), .clr_overflow(clr8));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ferr)  fe_hi++;
    if (ferr8) fe8_hi++;
  end

  // Packet model: a header opens a packet, five bytes close it, bit7 aborts it.
  function automatic void model_byte(input logic [7:0] b);
    evt_t e;
    int   xv, yv;
    if (b == 8'h80 || b == 8'h81) begin
      part_q.delete();
      part_q.push_back(b);
    end else if (b[7]) begin
      part_q.delete();
    end else if (part_q.size() > 0) begin
      part_q.push_back(b);
      if (part_q.size() == 5) begin
        xv = (int'(part_q[2]) % 32) * 128 + int'(part_q[1]);
        yv = (int'(part_q[4]) % 32) * 128 + int'(part_q[3]);
        e.pen = part_q[0][0];
        e.x   = xv[11:0];
        e.y   = yv[11:0];
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        else exp_ovf = 1'b1;
        part_q.delete();
      end
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop_bit,
                           input int bitclk, input bit to8);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (to8) rxd8 = frame[i];
      else     rxd  = frame[i];
      repeat (bitclk) @(negedge clk);
    end
    if (to8) rxd8 = 1'b1;
    else     rxd  = 1'b1;
    repeat (bitclk / 4) @(negedge clk);
  endtask

  task automatic send_model(input logic [7:0] b);
    send_byte(b, 1'b1, BIT_M, 1'b0);
    model_byte(b);
  endtask

  task automatic send_pkt(input logic p, input logic [11:0] px, input logic [11:0] py);
    send_model({7'b1000000, p});
    send_model({1'b0, px[6:0]});
    send_model({1'b0, 2'($urandom), px[11:7]});
    send_model({1'b0, py[6:0]});
    send_model({1'b0, 2'($urandom), py[11:7]});
  endtask

  task automatic do_reset();
    ready = 1'b0;
    clr   = 1'b0;
    rxd   = 1'b1;
    rxd8  = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    exp_q.delete();
    part_q.delete();
    exp_ovf = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({valid, pen, x, y, cnt, ferr, ovf} !== 31'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outs_in_reset: got %0h expected 0", {valid, pen, x, y, cnt, ferr, ovf});
    end
    tests_run++;
    if ({txd, txd8} !== 2'b11) begin
      tests_failed++;
      $display("[TB] FAIL reset_txd: got %b expected 11", {txd, txd8});
    end
    tests_run++;
    if ({valid8, pen8, x8, y8, cnt8, ferr8, ovf8} !== 25'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outs8: got %0h expected 0", {valid8, pen8, x8, y8, cnt8, ferr8, ovf8});
    end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    tests_run++;
    if ({txd, valid, cnt, ferr, ovf} !== 7'b1000000) begin
      tests_failed++;
      $display("[TB] FAIL reset_after_release: got %b expected 1000000", {txd, valid, cnt, ferr, ovf});
    end
  endtask

  task automatic test_basic();
    do_reset();
    send_model(8'h81); send_model(8'h7F); send_model(8'h1F);
    send_model(8'h00); send_model(8'h10);
    repeat (10) @(negedge clk);
    tests_run++;
    if (cnt !== 3'd1) begin
      tests_failed++;
      $display("[TB] FAIL basic_count: got %0d expected 1", cnt);
    end
    tests_run++;
    if ({valid, pen, x, y} !== {1'b1, 1'b1, 12'hFFF, 12'h800}) begin
      tests_failed++;
      $display("[TB] FAIL basic_event: got %0h expected %0h", {valid, pen, x, y}, {1'b1, 1'b1, 12'hFFF, 12'h800});
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    tests_run++;
    if ({valid, cnt} !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL basic_pop: got %b expected 0000", {valid, cnt});
    end
  endtask

  task automatic test_abort_header();
    do_reset();
    send_model(8'h81); send_model(8'h7F); send_model(8'h81); send_model(8'h01);
    send_model(8'h02); send_model(8'h03); send_model(8'h04);
    repeat (10) @(negedge clk);
    tests_run++;
    if ({cnt, valid, pen, x, y} !== {3'd1, 1'b1, 1'b1, 12'h101, 12'h203}) begin
      tests_failed++;
      $display("[TB] FAIL abort_header: got %0h expected %0h", {cnt, valid, pen, x, y}, {3'd1, 1'b1, 1'b1, 12'h101, 12'h203});
    end
  endtask

  task automatic test_frame_err();
    int base;
    do_reset();
    base = fe_hi;
    send_model(8'h81); send_model(8'h7F);
    send_byte(8'h7F, 1'b0, BIT_M, 1'b0);
    part_q.delete();
    send_model(8'h1F); send_model(8'h00); send_model(8'h10);
    repeat (10) @(negedge clk);
    tests_run++;
    if (fe_hi - base !== 1) begin
      tests_failed++;
      $display("[TB] FAIL frame_err_pulse: got %0d cycles expected 1", fe_hi - base);
    end
    tests_run++;
    if ({valid, cnt} !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL frame_err_no_event: got %b expected 0000", {valid, cnt});
    end
    send_model(8'h80); send_model(8'h11); send_model(8'h01);
    send_model(8'h22); send_model(8'h02);
    repeat (10) @(negedge clk);
    tests_run++;
    if ({cnt, valid, pen, x, y} !== {3'd1, 1'b1, 1'b0, 12'h091, 12'h122}) begin
      tests_failed++;
      $display("[TB] FAIL frame_err_recover: got %0h expected %0h", {cnt, valid, pen, x, y}, {3'd1, 1'b1, 1'b0, 12'h091, 12'h122});
    end
  endtask

  task automatic test_drain(input bit toggle);
    int   guard;
    logic rdy;
    guard = 0;
    rdy   = 1'b0;
    while ((exp_q.size() > 0 || valid) && guard < 200) begin
      tests_run++;
      if (cnt !== exp_q.size()) begin
        tests_failed++;
        $display("[TB] FAIL drain_count: got %0d expected %0d", cnt, exp_q.size());
      end
      if (exp_q.size() > 0) begin
        tests_run++;
        if ({valid, pen, x, y} !== {1'b1, exp_q[0]}) begin
          tests_failed++;
          $display("[TB] FAIL drain_head: got %0h expected %0h", {valid, pen, x, y}, {1'b1, exp_q[0]});
        end
      end
      rdy   = toggle ? ~rdy : 1'($urandom_range(0, 1));
      ready = rdy;
      @(negedge clk);
      if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
      guard++;
    end
    ready = 1'b0;
    tests_run++;
    if (guard >= 200 || {valid, cnt} !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL drain_end: got valid/count %b after %0d cycles expected 0000", {valid, cnt}, guard);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int p = 0; p < 5; p++)
      send_pkt(1'($urandom_range(0, 1)), 12'($urandom), 12'($urandom));
    repeat (10) @(negedge clk);
    tests_run++;
    if ({cnt, ovf} !== {3'd4, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL overflow_set: got count %0d ovf %b expected 4 1", cnt, ovf);
    end
    tests_run++;
    if ({valid, pen, x, y} !== {1'b1, exp_q[0]}) begin
      tests_failed++;
      $display("[TB] FAIL overflow_oldest: got %0h expected %0h", {valid, pen, x, y}, {1'b1, exp_q[0]});
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({cnt, ovf} !== {3'd4, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL overflow_clear: got count %0d ovf %b expected 4 0", cnt, ovf);
    end
    test_drain(1'b1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_pkt(1'b1, 12'h3A5, 12'h5C3);
    send_model(8'h81); send_model(8'h7F);
    rxd = 1'b0;
    repeat (3 * BIT_M) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({valid, cnt} !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_flush: got %b expected 0000", {valid, cnt});
    end
    rxd = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    exp_q.delete();
    part_q.delete();
    send_model(8'h1F); send_model(8'h00);
    send_pkt(1'b0, 12'($urandom), 12'($urandom));
    repeat (10) @(negedge clk);
    tests_run++;
    if ({cnt, valid, pen, x, y} !== {3'd1, 1'b1, exp_q[0]}) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_next: got %0h expected %0h", {cnt, valid, pen, x, y}, {3'd1, 1'b1, exp_q[0]});
    end
  endtask

  task automatic test_random();
    int n;
    do_reset();
    n = $urandom_range(2, 4);
    for (int p = 0; p < n; p++) begin
      if ($urandom_range(0, 2) == 0) send_model(8'($urandom));
      send_pkt(1'($urandom_range(0, 1)), 12'($urandom), 12'($urandom));
    end
    repeat (10) @(negedge clk);
    tests_run++;
    if ({cnt, ovf} !== {3'(exp_q.size()), exp_ovf}) begin
      tests_failed++;
      $display("[TB] FAIL random_fill: got count %0d ovf %b expected %0d %b", cnt, ovf, exp_q.size(), exp_ovf);
    end
    test_drain(1'b0);
  endtask

  task automatic test_coord8();
    do_reset();
    send_byte(8'h80, 1'b1, BIT_8, 1'b1); send_byte(8'h05, 1'b1, BIT_8, 1'b1);
    send_byte(8'h01, 1'b1, BIT_8, 1'b1); send_byte(8'h7F, 1'b1, BIT_8, 1'b1);
    send_byte(8'h00, 1'b1, BIT_8, 1'b1);
    repeat (10) @(negedge clk);
    tests_run++;
    if ({cnt8, valid8, pen8, x8, y8} !== {5'd1, 1'b1, 1'b0, 8'h08, 8'h07}) begin
      tests_failed++;
      $display("[TB] FAIL coord8_event: got %0h expected %0h", {cnt8, valid8, pen8, x8, y8}, {5'd1, 1'b1, 1'b0, 8'h08, 8'h07});
    end
  endtask

  task automatic test_glitch();
    int base;
    do_reset();
    base = fe8_hi;
    send_byte(8'h81, 1'b1, BIT_8, 1'b1); send_byte(8'h00, 1'b1, BIT_8, 1'b1);
    rxd8 = 1'b0;
    repeat (60) @(negedge clk);
    rxd8 = 1'b1;
    repeat (400) @(negedge clk);
    send_byte(8'h1F, 1'b1, BIT_8, 1'b1); send_byte(8'h7F, 1'b1, BIT_8, 1'b1);
    send_byte(8'h0A, 1'b1, BIT_8, 1'b1);
    repeat (10) @(negedge clk);
    tests_run++;
    if (fe8_hi - base !== 0) begin
      tests_failed++;
      $display("[TB] FAIL glitch_frame_err: got %0d cycles expected 0", fe8_hi - base);
    end
    tests_run++;
    if ({cnt8, valid8, pen8, x8, y8} !== {5'd1, 1'b1, 1'b1, 8'hF8, 8'h57}) begin
      tests_failed++;
      $display("[TB] FAIL glitch_event: got %0h expected %0h", {cnt8, valid8, pen8, x8, y8}, {5'd1, 1'b1, 1'b1, 8'hF8, 8'h57});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_abort_header();
    test_frame_err();
    test_overflow();
    test_reset_mid();
    test_random();
    test_coord8();
    test_glitch();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
